mem_port_arbiter: RTL and testbench

Parametrised arbiter that shares one line-wide memory port among NUM_CH requesters (instruction cache, data cache, future DMA/second core), replacing the fixed two-owner fetch-ownership logic in the CPU top. It serialises read-line and write-line transactions against the memory's read_ack/write_ack handshake. It latches the winning request, returns read data and a one-cycle completion pulse to the owner, and counts completed transfers.

---
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request-side and memory-side bus of the shared memory port.
//   Requester side : req_read, req_write, req_addr, req_wdata (in); grant, done, rdata (out)
//   Memory side    : readM, writeM, address, wdata (out); mem_rdata, read_ack, write_ack (in)
//   Packing        : channel i occupies [i*ADDR_W +: ADDR_W] / [i*LINE_W +: LINE_W]
//   Modports       : slave = arbiter view, master = requesters + memory view
interface mem_port_arbiter_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 64
);
  logic [NUM_CH-1:0]        req_read;
  logic [NUM_CH-1:0]        req_write;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*LINE_W-1:0] req_wdata;
  logic [NUM_CH-1:0]        grant;
  logic [NUM_CH-1:0]        done;
  logic [LINE_W-1:0]        rdata;
  logic                     readM;
  logic                     writeM;
  logic [ADDR_W-1:0]        address;
  logic [LINE_W-1:0]        wdata;
  logic [LINE_W-1:0]        mem_rdata;
  logic                     read_ack;
  logic                     write_ack;

  modport slave (
    input  req_read, req_write, req_addr, req_wdata, mem_rdata, read_ack, write_ack,
    output grant, done, rdata, readM, writeM, address, wdata
  );

  modport master (
    output req_read, req_write, req_addr, req_wdata, mem_rdata, read_ack, write_ack,
    input  grant, done, rdata, readM, writeM, address, wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one line-wide memory port among NUM_CH requesters.
// Serialises read-line / write-line transactions (IDLE -> BUSY -> DONE), latches
// the winning request, returns read data with a one-cycle done pulse to the owner
// and counts completed transfers.
// Ports:
//   Clk      : clock, rising edge
//   Reset_N  : synchronous active-low reset
//   bus      : mem_port_arbiter_if.slave (requests, grant/done/rdata, memory strobes/acks)
//   num_xfer : 16-bit completed-transaction counter, wraps
// Configuration:
//   MEM_ARB_RR_EN defined   : round-robin arbitration, pointer starts at 0
//   MEM_ARB_RR_EN undefined : fixed priority, lowest channel index wins
module mem_port_arbiter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 64
) (
  input  logic              Clk,
  input  logic              Reset_N,
  mem_port_arbiter_if.slave bus,
  output logic [15:0]       num_xfer
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic              readm_q, readm_d;
  logic              writem_q, writem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_d;

  logic [NUM_CH-1:0] pending;
  logic              win_vld;
  logic [CH_W-1:0]   win_idx;
  logic              xfer_end;

  logic [ADDR_W-1:0] addr_a  [NUM_CH];
  logic [LINE_W-1:0] wdata_a [NUM_CH];

  // Unpack per-channel address / write line
  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign addr_a[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = bus.req_wdata[g*LINE_W +: LINE_W];
  end

  assign pending = bus.req_read | bus.req_write;

`ifdef MEM_ARB_RR_EN
  logic [CH_W-1:0] rr_q, rr_d;
  logic [CH_W:0]   cand;

  // Round-robin: first pending channel at or after the pointer, wrapping
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int j = 0; j < int'(NUM_CH); j++) begin
      cand = (CH_W+1)'(rr_q) + (CH_W+1)'(j);
      if (cand >= (CH_W+1)'(NUM_CH)) cand = cand - (CH_W+1)'(NUM_CH);
      if (!win_vld && pending[cand[CH_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[CH_W-1:0];
      end
    end
  end
`else
  // Fixed priority: lowest pending index wins
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int j = int'(NUM_CH) - 1; j >= 0; j--) begin
      if (pending[j]) begin
        win_vld = 1'b1;
        win_idx = CH_W'(j);
      end
    end
  end
`endif

  // Only the ack matching the latched op ends the transaction
  assign xfer_end = (writem_q && bus.write_ack) || (readm_q && bus.read_ack);

  // Next-state and registered-output values
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    readm_d  = readm_q;
    writem_d = writem_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = num_xfer;
`ifdef MEM_ARB_RR_EN
    rr_d     = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d  = BUSY;
          grant_d  = NUM_CH'(1) << win_idx;
          // Write has precedence when a channel asserts both
          writem_d = bus.req_write[win_idx];
          readm_d  = !bus.req_write[win_idx];
          addr_d   = addr_a[win_idx];
          wdata_d  = wdata_a[win_idx];
`ifdef MEM_ARB_RR_EN
          rr_d     = (win_idx == CH_W'(NUM_CH - 1)) ? '0 : win_idx + CH_W'(1);
`endif
        end
      end
      BUSY: begin
        if (xfer_end) begin
          state_d  = DONE;
          done_d   = grant_q;
          grant_d  = '0;
          readm_d  = 1'b0;
          writem_d = 1'b0;
          cnt_d    = num_xfer + CNT_W'(1);
          if (readm_q) rdata_d = bus.mem_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      readm_q  <= 1'b0;
      writem_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      num_xfer <= '0;
`ifdef MEM_ARB_RR_EN
      rr_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      readm_q  <= readm_d;
      writem_q <= writem_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      num_xfer <= cnt_d;
`ifdef MEM_ARB_RR_EN
      rr_q     <= rr_d;
`endif
    end
  end

  assign bus.grant   = grant_q;
  assign bus.done    = done_q;
  assign bus.readM   = readm_q;
  assign bus.writeM  = writem_q;
  assign bus.address = addr_q;
  assign bus.wdata   = wdata_q;
  assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter (NUM_CH=2).
// Directed vector table, hand sequences (reset mid-transaction, counter wrap)
// and randomized transactions against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LINE_W = 64;

  logic        Clk = 1'b0;
  logic        Reset_N = 1'b0;
  logic [15:0] num_xfer;

  mem_port_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  mem_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .Clk      (Clk),
    .Reset_N  (Reset_N),
    .bus      (bus),
    .num_xfer (num_xfer)
  );

  always #5 Clk = ~Clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt = '0;
  int          rr_m = 0;

  typedef struct {
    logic [NUM_CH-1:0] rd;
    logic [NUM_CH-1:0] wr;
    int                dly;
    bit                wrong;
    logic [NUM_CH-1:0] g_fp;
    logic [NUM_CH-1:0] g_rr;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: which channel the rules say wins a pending set
  function automatic int model_win(input logic [NUM_CH-1:0] pend);
`ifdef MEM_ARB_RR_EN
    for (int j = 0; j < int'(NUM_CH); j++) begin
      int k;
      k = (rr_m + j) % int'(NUM_CH);
      if (pend[k]) return k;
    end
`else
    for (int k = 0; k < int'(NUM_CH); k++)
      if (pend[k]) return k;
`endif
    return 0;
  endfunction

  task automatic zero_inputs();
    bus.req_read  = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_rdata = '0;
    bus.read_ack  = 1'b0;
    bus.write_ack = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".grant"},   128'(bus.grant),   128'd0);
    chk({tag, ".done"},    128'(bus.done),    128'd0);
    chk({tag, ".readM"},   128'(bus.readM),   128'd0);
    chk({tag, ".writeM"},  128'(bus.writeM),  128'd0);
    chk({tag, ".address"}, 128'(bus.address), 128'd0);
    chk({tag, ".wdata"},   128'(bus.wdata),   128'd0);
    chk({tag, ".rdata"},   128'(bus.rdata),   128'd0);
    chk({tag, ".num_xfer"},128'(num_xfer),    128'd0);
  endtask

  // Reset for two edges; returns at a negedge with reset released
  task automatic do_reset();
    Reset_N = 1'b0;
    zero_inputs();
    @(negedge Clk);
    @(negedge Clk);
    chk_all_zero("reset");
    Reset_N = 1'b1;
    exp_cnt = '0;
    rr_m    = 0;
  endtask

  // One full transaction; starts and ends at a negedge in an idle cycle
  task automatic do_txn(input string tag,
                        input logic [NUM_CH-1:0] rd, input logic [NUM_CH-1:0] wr,
                        input logic [NUM_CH*ADDR_W-1:0] addr,
                        input logic [NUM_CH*LINE_W-1:0] wd,
                        input int dly, input bit wrong, input bit noise,
                        input logic [LINE_W-1:0] mrd, input logic [NUM_CH-1:0] eg);
    int w;
    bit ew;
    logic [ADDR_W-1:0] ea;
    logic [LINE_W-1:0] ewd;
    w = 0;
    for (int i = 0; i < int'(NUM_CH); i++) if (eg[i]) w = i;
    ew  = wr[w];
    ea  = addr[w*ADDR_W +: ADDR_W];
    ewd = wd[w*LINE_W +: LINE_W];
    rr_m = (w + 1) % int'(NUM_CH);

    bus.req_read  = rd;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(negedge Clk);
    chk({tag, ".grant"},   128'(bus.grant),   128'(eg));
    chk({tag, ".readM"},   128'(bus.readM),   128'(!ew));
    chk({tag, ".writeM"},  128'(bus.writeM),  128'(ew));
    chk({tag, ".address"}, 128'(bus.address), 128'(ea));
    chk({tag, ".wdata"},   128'(bus.wdata),   128'(ewd));
    chk({tag, ".done0"},   128'(bus.done),    128'd0);

    for (int c = 0; c < dly; c++) begin
      if (wrong) begin
        if (ew) bus.read_ack = 1'b1;
        else    bus.write_ack = 1'b1;
      end
      if (noise) begin
        bus.req_read  = NUM_CH'($urandom);
        bus.req_write = NUM_CH'($urandom);
        bus.req_addr  = $urandom;
        bus.mem_rdata = {$urandom, $urandom};
      end
      @(negedge Clk);
      bus.read_ack  = 1'b0;
      bus.write_ack = 1'b0;
      chk({tag, ".hold_grant"}, 128'(bus.grant),   128'(eg));
      chk({tag, ".hold_addr"},  128'(bus.address), 128'(ea));
      chk({tag, ".hold_strb"},  128'({bus.readM, bus.writeM}), 128'({!ew, ew}));
      chk({tag, ".hold_done"},  128'(bus.done),    128'd0);
    end

    if (ew) bus.write_ack = 1'b1;
    else begin
      bus.read_ack  = 1'b1;
      bus.mem_rdata = mrd;
    end
    @(negedge Clk);
    bus.read_ack  = 1'b0;
    bus.write_ack = 1'b0;
    bus.mem_rdata = {$urandom, $urandom};
    exp_cnt = exp_cnt + 16'd1;
    chk({tag, ".done"},     128'(bus.done),  128'(eg));
    chk({tag, ".grant_off"},128'(bus.grant), 128'd0);
    chk({tag, ".strb_off"}, 128'({bus.readM, bus.writeM}), 128'd0);
    chk({tag, ".num_xfer"}, 128'(num_xfer),  128'(exp_cnt));
    if (!ew) chk({tag, ".rdata"}, 128'(bus.rdata), 128'(mrd));
    // Requester drops in the done cycle; stray acks here must be ignored
    bus.req_read  = '0;
    bus.req_write = '0;
    bus.read_ack  = 1'b1;
    bus.write_ack = 1'b1;
    @(negedge Clk);
    bus.read_ack  = 1'b0;
    bus.write_ack = 1'b0;
    chk({tag, ".idle_done"},  128'(bus.done),  128'd0);
    chk({tag, ".idle_grant"}, 128'(bus.grant), 128'd0);
    chk({tag, ".idle_cnt"},   128'(num_xfer),  128'(exp_cnt));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NUM_CH-1:0]        rd, wr, eg;
    logic [NUM_CH*ADDR_W-1:0] addr;
    logic [NUM_CH*LINE_W-1:0] wd;
    logic [ADDR_W-1:0]        a0;
    logic [LINE_W-1:0]        w0;
    int                       w;

    tbl[0] = '{2'b11, 2'b00, 1, 1'b0, 2'b01, 2'b01};
    tbl[1] = '{2'b11, 2'b00, 0, 1'b0, 2'b01, 2'b10};
    tbl[2] = '{2'b11, 2'b00, 2, 1'b1, 2'b01, 2'b01};
    tbl[3] = '{2'b11, 2'b00, 0, 1'b0, 2'b01, 2'b10};
    tbl[4] = '{2'b10, 2'b10, 2, 1'b0, 2'b10, 2'b10};
    tbl[5] = '{2'b10, 2'b00, 1, 1'b0, 2'b10, 2'b10};
    tbl[6] = '{2'b00, 2'b01, 0, 1'b0, 2'b01, 2'b01};
    tbl[7] = '{2'b01, 2'b10, 1, 1'b1, 2'b01, 2'b10};

    zero_inputs();
    do_reset();

    // Single read, ack in the third BUSY cycle
    do_txn("single_read", 2'b01, 2'b00, {16'h0000, 16'h0040}, '0, 2, 1'b0, 1'b0,
           64'h1111_2222_3333_4444, 2'b01);

    // Directed table, from a fresh reset
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a0 = 16'h0040 + 16'(i);
      w0 = 64'h0123_4567_89AB_CDEF ^ 64'(i);
`ifdef MEM_ARB_RR_EN
      eg = tbl[i].g_rr;
`else
      eg = tbl[i].g_fp;
`endif
      do_txn($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].wr, {16'h0100, a0},
             {64'hAAAA_BBBB_CCCC_DDDD, w0}, tbl[i].dly, tbl[i].wrong, 1'b0,
             64'h1111_2222_3333_4444 + 64'(i), eg);
    end

    // Reset while a write is in flight; a late write_ack must not produce done
    bus.req_write = 2'b01;
    bus.req_addr  = {16'h0000, 16'h0200};
    bus.req_wdata = {64'd0, 64'hDEAD_BEEF_0000_0001};
    @(negedge Clk);
    chk("rst_busy.writeM", 128'(bus.writeM), 128'd1);
    Reset_N = 1'b0;
    zero_inputs();
    @(negedge Clk);
    chk_all_zero("rst_busy");
    Reset_N = 1'b1;
    exp_cnt = '0;
    rr_m    = 0;
    @(negedge Clk);
    bus.write_ack = 1'b1;
    @(negedge Clk);
    bus.write_ack = 1'b0;
    chk("rst_late_ack.done",  128'(bus.done),  128'd0);
    chk("rst_late_ack.grant", 128'(bus.grant), 128'd0);
    @(negedge Clk);
    chk("rst_late_ack.done2", 128'(bus.done),  128'd0);
    chk("rst_late_ack.cnt",   128'(num_xfer),  128'd0);

    // Counter wrap from 0xFFFF
    force dut.num_xfer = 16'hFFFF;
    #1;
    release dut.num_xfer;
    exp_cnt = 16'hFFFF;
    do_txn("wrap", 2'b10, 2'b00, {16'h0300, 16'h0000}, '0, 0, 1'b0, 1'b0,
           64'h5555_6666_7777_8888, 2'b10);
    do_txn("post_wrap", 2'b00, 2'b01, {16'h0000, 16'h0304}, {64'd0, 64'h9999}, 1, 1'b0, 1'b0,
           '0, 2'b01);

    // Randomized transactions against the reference model
    for (int n = 0; n < 200; n++) begin
      rd = NUM_CH'($urandom);
      wr = NUM_CH'($urandom);
      if ((rd | wr) == '0) rd[$urandom_range(NUM_CH-1, 0)] = 1'b1;
      addr = {$urandom, $urandom} >> (64 - NUM_CH*ADDR_W);
      wd   = {$urandom, $urandom, $urandom, $urandom};
      w    = model_win(rd | wr);
      eg   = NUM_CH'(1) << w;
      do_txn($sformatf("rnd%0d", n), rd, wr, addr, wd, $urandom_range(4, 0),
             1'($urandom), 1'b1, {$urandom, $urandom}, eg);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
